// File: rtl/pll_reset_seq.sv
// pll_reset_seq: qualifies PLL lock and sequences staged core/peripheral reset release with loss tracking.
module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PERIPH_DELAY       = 64,
    parameter int CNT_W              = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             clear_lost,
    output logic             core_rst_n,
    output logic             periph_rst_n,
    output logic             ready,
    output logic             lost_flag,
    output logic [CNT_W-1:0] loss_count
);
    localparam int MX = LOCK_STABLE_CYCLES > PERIPH_DELAY ? LOCK_STABLE_CYCLES : PERIPH_DELAY;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_DELAY - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE_CORE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s, loss;
    logic [CNT_W-1:0]       count_base, count_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                state_d = locked_s ? STABLE : WAIT_LOCK;
                cnt_d   = '0;
            end
            STABLE: begin
                state_d = !locked_s ? WAIT_LOCK : cnt_q == STABLE_LAST ? RELEASE_CORE : STABLE;
                cnt_d   = state_d == STABLE ? cnt_q + CW'(1) : '0;
            end
            RELEASE_CORE: begin
                loss    = !locked_s;
                state_d = cnt_q == PERIPH_LAST ? RUN : RELEASE_CORE;
                cnt_d   = state_d == RUN ? '0 : cnt_q + CW'(1);
            end
            default: loss = !locked_s;
        endcase
        // a loss overrides any progress decided above, including the RUN transition
        if (loss) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
        count_base = clear_lost ? '0 : loss_count;
        count_d    = loss && !(&count_base) ? count_base + CNT_W'(1) : count_base;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sync_q       <= '0;
            core_rst_n   <= 1'b0;
            periph_rst_n <= 1'b0;
            ready        <= 1'b0;
            lost_flag    <= 1'b0;
            loss_count   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], locked};
            core_rst_n   <= state_d == RELEASE_CORE || state_d == RUN;
            periph_rst_n <= state_d == RUN;
            ready        <= state_d == RUN;
            lost_flag    <= loss || (lost_flag && !clear_lost);
            loss_count   <= count_d;
        end
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenario bench for pll_reset_seq with small parameters.
module tb_pll_reset_seq;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       locked = 1'b0;
    logic       clear_lost = 1'b0;
    logic       core_rst_n, periph_rst_n, ready, lost_flag;
    logic [1:0] loss_count;
    logic [5:0] obs, exp;
    int         total = 0;
    int         bad = 0;

    pll_reset_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(4),
        .PERIPH_DELAY(3),
        .CNT_W(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .locked(locked),
        .clear_lost(clear_lost),
        .core_rst_n(core_rst_n),
        .periph_rst_n(periph_rst_n),
        .ready(ready),
        .lost_flag(lost_flag),
        .loss_count(loss_count)
    );

    always #5 clock = ~clock;

    assign obs = {core_rst_n, periph_rst_n, ready, lost_flag, loss_count};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        locked  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 6'b0);
            end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = {i >= 7, i >= 10, i >= 10, 1'b0, 2'd0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL powerup edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_loss_run();
        locked = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp = i >= 3 ? 6'b000101 : 6'b111000;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL loss_run edge %0d: got %b want %b", i, obs, exp);
            end
        end
        locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = {i >= 7, i >= 10, i >= 10, 1'b1, 2'd1};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL relock edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        reset_n = 1'b0;
        locked  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            locked = i != 4;
            step();
            exp = {i >= 11, i >= 14, i >= 14, 1'b0, 2'd0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_loss_release();
        reset_n = 1'b0;
        locked  = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        total++;
        if (obs !== 6'b100000) begin
            bad++;
            $display("FAIL core_up: got %b want %b", obs, 6'b100000);
        end
        locked = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp = i >= 3 ? 6'b000101 : 6'b100000;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL loss_release edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_saturation();
        reset_n = 1'b0;
        locked  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            locked = 1'b1;
            for (int i = 1; i <= 7; i++) step();
            locked = 1'b0;
            step();
            step();
            clear_lost = k == 7;
            step();
            clear_lost = 1'b0;
            exp = {3'b000, 1'b1, k >= 6 ? 2'd1 : k >= 3 ? 2'd3 : 2'(k)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL loss_count event %0d: got %b want %b", k, obs, exp);
            end
            if (k == 5) begin
                clear_lost = 1'b1;
                step();
                clear_lost = 1'b0;
                total++;
                if (obs !== 6'b000000) begin
                    bad++;
                    $display("FAIL clear_lost: got %b want %b", obs, 6'b000000);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        locked = 1'b1;
        for (int i = 1; i <= 8; i++) step();
        total++;
        if (obs !== 6'b100101) begin
            bad++;
            $display("FAIL mid_core_up: got %b want %b", obs, 6'b100101);
        end
        reset_n = 1'b0;
        step();
        total++;
        if (obs !== 6'b000000) begin
            bad++;
            $display("FAIL mid_reset: got %b want %b", obs, 6'b000000);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = {i >= 7, i >= 10, i >= 10, 1'b0, 2'd0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mid_relaunch edge %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loss_run();
        test_glitch();
        test_loss_release();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
